// File: rtl/poly_coeff_ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : poly_coeff_ram_if
//  Description : Bus bundle for the polynomial coefficient RAM: clear
//                request/ready handshake, write port, read port, error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface poly_coeff_ram_if #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11
);
  logic                     clear_req;
  logic                     ready;
  logic                     write_enable;
  logic [RAM_ADDR_BITS-1:0] write_address;
  logic [RAM_WIDTH-1:0]     input_data;
  logic                     read_enable;
  logic [RAM_ADDR_BITS-1:0] read_address;
  logic [RAM_WIDTH-1:0]     output_data;
  logic                     output_valid;
  logic                     addr_err;

  // Requester side
  modport master (
    output clear_req, write_enable, write_address, input_data,
           read_enable, read_address,
    input  ready, output_data, output_valid, addr_err
  );

  // RAM side
  modport slave (
    input  clear_req, write_enable, write_address, input_data,
           read_enable, read_address,
    output ready, output_data, output_valid, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/poly_coeff_ram.sv
`default_nettype none
// ============================================================================
//  Module      : poly_coeff_ram
//  Description : Coefficient store with RAM_DEPTH valid words, a self-clearing
//                zero-fill engine (runs after reset and on clear_req), range
//                checking with a sticky addr_err flag, and a combinational or
//                one-cycle registered read port.
//  Options     : define POLY_COEFF_RAM_BYPASS_EN to forward same-cycle write
//                data to a colliding read (otherwise old content is returned).
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_coeff_ram #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11,
  parameter int RAM_DEPTH     = 757,
  parameter int READ_REG      = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  poly_coeff_ram_if.slave bus
);

  localparam int                     MEM_WORDS = 2 ** RAM_ADDR_BITS;
  // Depth held one bit wider so RAM_DEPTH == 2**RAM_ADDR_BITS still compares correctly
  localparam logic [RAM_ADDR_BITS:0] DEPTH_EXT = (RAM_ADDR_BITS+1)'(RAM_DEPTH);
  localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [RAM_ADDR_BITS-1:0] clr_cnt;
  logic [RAM_ADDR_BITS-1:0] clr_cnt_next;

  logic [RAM_WIDTH-1:0]     mem [0:MEM_WORDS-1];

  logic                     ready;
  logic                     wr_in_range;
  logic                     rd_in_range;
  logic                     wr_commit;
  logic                     rd_accept;
  logic                     err_hit;
  logic                     clear_start;
  logic                     mem_we;
  logic [RAM_ADDR_BITS-1:0] mem_waddr;
  logic [RAM_WIDTH-1:0]     mem_wdata;
  logic [RAM_WIDTH-1:0]     rd_data;
  logic                     addr_err;

  assign ready       = (state == ST_IDLE);
  assign wr_in_range = ({1'b0, bus.write_address} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, bus.read_address}  < DEPTH_EXT);
  assign wr_commit   = bus.write_enable & ready & wr_in_range;
  assign rd_accept   = bus.read_enable & ready;
  assign err_hit     = ready & ((bus.write_enable & ~wr_in_range) |
                                (bus.read_enable  & ~rd_in_range));
  assign clear_start = ready & bus.clear_req;

  assign bus.ready    = ready;
  assign bus.addr_err = addr_err;

  // FSM state and clear counter; reset parks in CLEAR so the array self-fills
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Next-state: clear_req only matters in IDLE, so a running clear is never extended
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      ST_IDLE: begin
        if (bus.clear_req) begin
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == LAST_IDX) begin
          state_next   = ST_IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_next   = ST_CLEAR;
        clr_cnt_next = '0;
      end
    endcase
  end

  // Single array write port shared by the clear engine and the user write
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.write_address;
    mem_wdata = bus.input_data;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end else if (wr_commit) begin
      mem_we    = 1'b1;
    end
  end

  // Storage array, intentionally without reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read mux: out-of-range reads yield zero; optional write-to-read forwarding
  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = mem[bus.read_address];
    end
`ifdef POLY_COEFF_RAM_BYPASS_EN
    if (wr_commit && (bus.write_address == bus.read_address)) begin
      rd_data = bus.input_data;
    end
`endif
  end

  // Sticky range-error flag; starting a clear wipes it even if an error hits that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
    end else if (clear_start) begin
      addr_err <= 1'b0;
    end else if (err_hit) begin
      addr_err <= 1'b1;
    end
  end

  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [RAM_WIDTH-1:0] out_data;
      logic                 out_valid;

      // Registered read: capture on accept, otherwise hold data and drop valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_data  <= '0;
          out_valid <= 1'b0;
        end else if (rd_accept) begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end

      assign bus.output_data  = out_data;
      assign bus.output_valid = out_valid;
    end else begin : g_read_comb
      assign bus.output_data  = rd_data;
      assign bus.output_valid = rd_accept;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_poly_coeff_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_coeff_ram
//  Description : Directed self-checking bench for poly_coeff_ram with default
//                parameters (registered read).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_coeff_ram;

  localparam int W  = 13;
  localparam int AB = 11;
  localparam int D  = 757;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   n;

  poly_coeff_ram_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) bus ();

  poly_coeff_ram #(
    .RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .RAM_DEPTH(D), .READ_REG(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (bus.ready !== 1'b1 && cnt < 5000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_write(input logic [AB-1:0] a, input logic [W-1:0] d);
    bus.write_enable  = 1'b1;
    bus.write_address = a;
    bus.input_data    = d;
    tick();
    bus.write_enable  = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AB-1:0] a, input logic [W-1:0] exp);
    bus.read_enable  = 1'b1;
    bus.read_address = a;
    tick();
    bus.read_enable  = 1'b0;
    check({tag, "_valid"}, 32'(bus.output_valid), 32'd1);
    check({tag, "_data"},  32'(bus.output_data),  32'(exp));
  endtask

  initial begin
    logic [W-1:0] exp_coll;
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.clear_req     = 1'b0;
    bus.write_enable  = 1'b0;
    bus.write_address = '0;
    bus.input_data    = '0;
    bus.read_enable   = 1'b0;
    bus.read_address  = '0;

    // Reset state
    tick(); tick();
    check("rst_ready",    32'(bus.ready),        32'd0);
    check("rst_valid",    32'(bus.output_valid), 32'd0);
    check("rst_data",     32'(bus.output_data),  32'd0);
    check("rst_addr_err", 32'(bus.addr_err),     32'd0);

    // Automatic clear after reset release lasts exactly D cycles
    rst_n = 1'b1;
    wait_ready(n);
    check("init_clear_cycles", 32'(n), 32'(D));
    do_read("init_rd0",   11'd0,   13'h0);
    do_read("init_rd756", 11'd756, 13'h0);

    // Write then registered read; data and valid one cycle later
    do_write(11'd5, 13'h11EF);
    do_read("rd5", 11'd5, 13'h11EF);
    tick();
    check("hold_valid", 32'(bus.output_valid), 32'd0);
    check("hold_data",  32'(bus.output_data),  32'h11EF);

    // Same-cycle write/read collision on address 9
    do_write(11'd9, 13'h0123);
`ifdef POLY_COEFF_RAM_BYPASS_EN
    exp_coll = 13'h0ABC;
`else
    exp_coll = 13'h0123;
`endif
    bus.write_enable  = 1'b1;
    bus.write_address = 11'd9;
    bus.input_data    = 13'h0ABC;
    do_read("collide9", 11'd9, exp_coll);
    bus.write_enable  = 1'b0;
    do_read("after_coll9", 11'd9, 13'h0ABC);

    // Top valid address is writable and raises no error; first invalid one does
    do_write(11'd756, 13'h1FFF);
    do_read("rd756", 11'd756, 13'h1FFF);
    check("no_err_756", 32'(bus.addr_err), 32'd0);
    do_write(11'd757, 13'h1234);
    check("err_757", 32'(bus.addr_err), 32'd1);
    do_write(11'd800, 13'h0F0F);
    check("err_800", 32'(bus.addr_err), 32'd1);
    do_read("oor_rd800", 11'd800, 13'h0);
    do_read("oor_rd757", 11'd757, 13'h0);
    do_read("unchanged5", 11'd5, 13'h11EF);

    // Write to 3 alongside clear_req: write lands, then clear overwrites it
    bus.clear_req     = 1'b1;
    bus.write_enable  = 1'b1;
    bus.write_address = 11'd3;
    bus.input_data    = 13'h0777;
    tick();
    bus.write_enable  = 1'b0;
    check("clr_ready_low", 32'(bus.ready),    32'd0);
    check("clr_err_drop",  32'(bus.addr_err), 32'd0);
    // clear_req held for a few cycles must not restart the clear
    tick(); tick(); tick();
    bus.clear_req = 1'b0;
    tick(); tick();
    // Counter is past 2 now: a write to 2 would survive if not dropped
    bus.write_enable  = 1'b1;
    bus.write_address = 11'd2;
    bus.input_data    = 13'h1555;
    bus.read_enable   = 1'b1;
    bus.read_address  = 11'd5;
    tick();
    bus.write_enable  = 1'b0;
    bus.read_enable   = 1'b0;
    check("busy_rd_valid", 32'(bus.output_valid), 32'd0);
    wait_ready(n);
    check("clear_cycles", 32'(n + 6), 32'(D));
    do_read("clr_rd3", 11'd3, 13'h0);
    do_read("clr_rd2", 11'd2, 13'h0);
    do_read("clr_rd5", 11'd5, 13'h0);
    do_read("clr_rd756", 11'd756, 13'h0);

    // Reset pulsed at clear cycle 300 restarts the full clear
    do_write(11'd7, 13'h0AAA);
    do_read("pre_rd7", 11'd7, 13'h0AAA);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (300) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_data",  32'(bus.output_data),  32'd0);
    check("mid_rst_valid", 32'(bus.output_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.ready),        32'd0);
    tick();
    rst_n = 1'b1;
    wait_ready(n);
    check("restart_cycles", 32'(n), 32'(D));
    do_read("rst_rd7",   11'd7,   13'h0);
    do_read("rst_rd756", 11'd756, 13'h0);
    check("final_err", 32'(bus.addr_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/poly_coeff_ram.md
POLY_COEFF_RAM -- requirements
Module: poly_coeff_ram

Interface
REQ-001 Parameter RAM_WIDTH, default 13: coefficient word width in bits.
REQ-002 Parameter RAM_ADDR_BITS, default 11: address width; storage array holds 2**RAM_ADDR_BITS words.
REQ-003 Parameter RAM_DEPTH, default 757: number of valid entries; valid addresses are 0..RAM_DEPTH-1; legal range is RAM_DEPTH <= 2**RAM_ADDR_BITS.
REQ-004 Parameter READ_REG, default 1: 0 = combinational read, 1 = one-cycle registered read.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 clear_req  input  1  request to zero-fill entries 0..RAM_DEPTH-1.
REQ-008 ready  output  1  high when the block is idle and accepts reads and writes.
REQ-009 write_enable  input  1  write strobe.
REQ-010 write_address  input  RAM_ADDR_BITS  write address.
REQ-011 input_data  input  RAM_WIDTH  write data.
REQ-012 read_enable  input  1  read strobe.
REQ-013 read_address  input  RAM_ADDR_BITS  read address.
REQ-014 output_data  output  RAM_WIDTH  read data.
REQ-015 output_valid  output  1  output_data holds the result of an accepted read.
REQ-016 addr_err  output  1  sticky flag, set by any out-of-range access.

Function
REQ-017 The FSM SHALL have two states: IDLE (ready=1) and CLEAR (ready=0).
REQ-018 In IDLE, clear_req=1 SHALL move the FSM to CLEAR with the clear counter at 0; ready SHALL go low on the next cycle.
REQ-019 In CLEAR, each cycle SHALL write 0 to entry[counter] and increment the counter; after the write to entry RAM_DEPTH-1, the FSM SHALL return to IDLE, so a clear takes exactly RAM_DEPTH cycles.
REQ-020 clear_req SHALL be ignored while in CLEAR; a clear is never restarted or extended.
REQ-021 A write SHALL commit input_data to entry[write_address] on the rising edge when write_enable=1, ready=1 and write_address<RAM_DEPTH.
REQ-022 In IDLE, write_enable and clear_req asserted in the same cycle: the write SHALL commit first, and the clear SHALL then overwrite the entry.
REQ-023 Writes and reads while ready=0 SHALL be dropped with no effect on the array, and output_valid SHALL be 0.
REQ-024 READ_REG=1: a read accepted (read_enable=1, ready=1) in cycle N SHALL present the data and output_valid=1 in cycle N+1; with no accepted read, output_valid SHALL be 0 and output_data SHALL hold its last value.
REQ-025 READ_REG=0: output_data SHALL equal entry[read_address] combinationally, and output_valid SHALL equal read_enable AND ready.
REQ-026 A read with read_address>=RAM_DEPTH SHALL return 0 with output_valid asserted as normal.
REQ-027 Any write or read with an address >= RAM_DEPTH, strobed while ready=1, SHALL set addr_err; addr_err SHALL clear only on reset or at the start of a clear.
REQ-028 Entries at index RAM_DEPTH and above SHALL never be written.

Reset
REQ-029 rst_n=0 SHALL immediately force: FSM=CLEAR, counter=0, ready=0, output_valid=0, output_data=0, addr_err=0.
REQ-030 The storage array SHALL have no reset; after rst_n deasserts, the automatic clear SHALL zero-fill it within RAM_DEPTH cycles.
REQ-031 Reset asserted in the middle of a clear SHALL restart the clear from counter 0 once rst_n deasserts.

Configuration
REQ-032 When macro POLY_COEFF_RAM_BYPASS_EN is defined, a read accepted in the same cycle as a committed write to the same address SHALL return the new input_data, for both values of READ_REG.
REQ-033 When POLY_COEFF_RAM_BYPASS_EN is undefined, the same collision SHALL return the old entry content.

Verification
REQ-034 Reset release, defaults -> ready=0 for exactly 757 cycles then 1; a read of address 0..756 returns 0.
REQ-035 Write 0x11EF to address 5, then read address 5 with READ_REG=1 -> output_data=0x11EF and output_valid=1 exactly one cycle after the read.
REQ-036 Same-cycle write 0x0ABC and read of address 9, which holds 0x0123 -> returns 0x0ABC with bypass defined and 0x0123 without it.
REQ-037 Write to address 800 -> array unchanged, addr_err=1; a later clear_req drops addr_err to 0.
REQ-038 clear_req while in IDLE, with rst_n pulsed low at clear cycle 300 -> after release, ready stays low for another 757 cycles and all entries read 0.
REQ-039 Write 0x0777 to address 3 with clear_req in the same cycle -> after the clear completes, address 3 reads 0.
